// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF challenge controller: state encoding,
// LFSR geometry and small combinational helpers.
package puf_ctrl_pkg;

    localparam int unsigned PUF_W = 128;

    // Fibonacci tap positions, 1-based as in the polynomial x^128+x^126+x^101+x^99+1
    localparam int unsigned TAP_A = 128;
    localparam int unsigned TAP_B = 126;
    localparam int unsigned TAP_C = 101;
    localparam int unsigned TAP_D = 99;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SAMPLE    = 3'd4,
        ST_DONE      = 3'd5
    } puf_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [PUF_W-1:0] bit_rev128(input logic [PUF_W-1:0] v);
        logic [PUF_W-1:0] r;
        for (int i = 0; i < PUF_W; i++) begin
            r[i] = v[PUF_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/puf_challenge_ctrl_if.sv
// Request/response handshake bundle between a consumer and puf_challenge_ctrl.
interface puf_challenge_ctrl_if #(
    parameter int unsigned RESP_BITS = 32
) ();
    logic                 start;
    logic [127:0]         challenge;
    logic                 busy;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] response;

    modport master (
        output start, challenge, resp_ready,
        input  busy, resp_valid, response
    );

    modport slave (
        input  start, challenge, resp_ready,
        output busy, resp_valid, response
    );
endinterface

// File: rtl/puf_lfsr128.sv
// 128-bit Fibonacci LFSR generating PDL configuration words; an all-zero seed
// is replaced by 1 so the register can never lock up.
module puf_lfsr128
    import puf_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [PUF_W-1:0] i_seed,
    output logic [PUF_W-1:0] o_state
);

    logic [PUF_W-1:0] r_state;
    logic             w_fb;

    assign w_fb    = r_state[TAP_A-1] ^ r_state[TAP_B-1] ^ r_state[TAP_C-1] ^ r_state[TAP_D-1];
    assign o_state = r_state;

    // Seed load has priority over stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= {PUF_W{1'b0}};
        end else if (i_load) begin
            r_state <= (i_seed == {PUF_W{1'b0}}) ? {{(PUF_W-1){1'b0}}, 1'b1} : i_seed;
        end else if (i_step) begin
            r_state <= {r_state[PUF_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/puf_challenge_ctrl.sv
// Arbiter-PUF challenge sequencer: precharge/launch/settle/sample per response bit.
// Optional macro PUF_MAJORITY_VOTE_EN evaluates each bit three times and votes.
module puf_challenge_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned RESP_BITS     = 32,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    puf_challenge_ctrl_if.slave    bus,
    output logic [PUF_W-1:0]       config1,
    output logic [PUF_W-1:0]       config2,
    output logic                   puf_a,
    output logic                   puf_b,
    input  logic                   puf_c
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_PRE    = ST_PRECHARGE;
    localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [2:0] S_SETTLE = ST_SETTLE;
    localparam logic [2:0] S_SAMPLE = ST_SAMPLE;
    localparam logic [2:0] S_DONE   = ST_DONE;

    localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned BC_W = $clog2(RESP_BITS + 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [SC_W-1:0]      r_set_cnt;
    logic [BC_W-1:0]      r_bit_cnt;
    logic [RESP_BITS-1:0] r_resp;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_puf;
    logic                 w_load;
    logic                 w_step;
    logic                 w_settle_done;
    logic                 w_last_eval;
    logic                 w_bit;
    logic [PUF_W-1:0]     w_lfsr;

    assign w_settle_done  = (r_set_cnt == SC_W'(SETTLE_CYCLES - 1));
    assign bus.busy       = r_busy;
    assign bus.resp_valid = r_valid;
    assign bus.response   = r_resp;
    assign puf_a          = r_puf;
    assign puf_b          = r_puf;
    assign config1        = w_lfsr;
    assign config2        = bit_rev128(w_lfsr);

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] r_vote_cnt;
    logic [1:0] r_votes;

    assign w_last_eval = (r_vote_cnt == 2'd2);
    assign w_bit       = maj3(r_votes[0], r_votes[1], puf_c);

    // Collect the first two samples of each bit; the third is voted directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote_cnt <= 2'd0;
            r_votes    <= 2'd0;
        end else if (w_load) begin
            r_vote_cnt <= 2'd0;
            r_votes    <= 2'd0;
        end else if (r_state == S_SAMPLE) begin
            if (w_last_eval) begin
                r_vote_cnt <= 2'd0;
            end else begin
                r_vote_cnt             <= r_vote_cnt + 2'd1;
                r_votes[r_vote_cnt[0]] <= puf_c;
            end
        end
    end
`else
    assign w_last_eval = 1'b1;
    assign w_bit       = puf_c;
`endif

    puf_lfsr128 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_seed  (bus.challenge),
        .o_state (w_lfsr)
    );

    // Next-state decode and LFSR control strobes
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_PRE;
                    w_load = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PRE:    w_next = w_settle_done ? S_LAUNCH : S_PRE;
            S_LAUNCH: w_next = S_SETTLE;
            S_SETTLE: w_next = w_settle_done ? S_SAMPLE : S_SETTLE;
            S_SAMPLE: begin
                if (w_last_eval) begin
                    w_step = 1'b1;
                    w_next = (r_bit_cnt == BC_W'(RESP_BITS - 1)) ? S_DONE : S_PRE;
                end else begin
                    w_next = S_PRE;
                end
            end
            S_DONE:   w_next = bus.resp_ready ? S_IDLE : S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State, registered outputs (decoded from next state), timers and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_puf     <= 1'b0;
            r_set_cnt <= {SC_W{1'b0}};
            r_bit_cnt <= {BC_W{1'b0}};
            r_resp    <= {RESP_BITS{1'b0}};
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_valid <= (w_next == S_DONE);
            r_puf   <= (w_next == S_LAUNCH) || (w_next == S_SETTLE);
            if (((r_state == S_PRE) || (r_state == S_SETTLE)) && !w_settle_done) begin
                r_set_cnt <= r_set_cnt + SC_W'(1);
            end else begin
                r_set_cnt <= {SC_W{1'b0}};
            end
            if (w_load) begin
                r_resp    <= {RESP_BITS{1'b0}};
                r_bit_cnt <= {BC_W{1'b0}};
            end else if ((r_state == S_SAMPLE) && w_last_eval) begin
                r_resp    <= (r_resp << 1) | RESP_BITS'(w_bit);
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
        end
    end

endmodule

// File: doc/puf_challenge_ctrl.md
PUF_CHALLENGE_CTRL -- requirements
Module: puf_challenge_ctrl

Interface
REQ-001 SHALL have parameter RESP_BITS, default 32, response length in bits; legal range 1..128.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8, precharge and settle wait in cycles; legal minimum 1.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port challenge  in  128  seed challenge; captured when start is accepted.
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port resp_valid  out  1  response available.
REQ-009 SHALL have port resp_ready  in  1  consumer accepts response.
REQ-010 SHALL have port response  out  RESP_BITS  collected response bits.
REQ-011 SHALL have ports config1 and config2  out  128  PDL control words to the PUF datapath.
REQ-012 SHALL have ports puf_a and puf_b  out  1  race operands to both adder paths.
REQ-013 SHALL have port puf_c  in  1  arbiter output from the PUF datapath.

Function
REQ-014 SHALL implement FSM states IDLE, PRECHARGE, LAUNCH, SETTLE, SAMPLE and DONE.
REQ-015 IDLE with start=1 SHALL capture challenge into the LFSR, clear response and the bit counter, and go to PRECHARGE. An all-zero challenge SHALL be replaced by 128'h1.
REQ-016 PRECHARGE SHALL drive puf_a=puf_b=0 for SETTLE_CYCLES cycles, then go to LAUNCH.
REQ-017 LAUNCH SHALL drive puf_a=puf_b=1 for 1 cycle, then go to SETTLE.
REQ-018 SETTLE SHALL hold puf_a=puf_b=1 for SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL shift puf_c into response bit 0, shifting older bits toward the MSB, in 1 cycle.
REQ-020 SAMPLE SHALL also step the LFSR and increment the bit counter.
REQ-021 From SAMPLE, the FSM SHALL go to DONE when the counter reaches RESP_BITS, else to PRECHARGE.
REQ-022 Each response bit SHALL take 2*SETTLE_CYCLES+2 cycles; with defaults, resp_valid SHALL rise 576 cycles after start is accepted.
REQ-023 The LFSR SHALL be 128-bit Fibonacci with taps 128,126,101,99, shifting left with feedback into bit 0.
REQ-024 config1 SHALL equal the LFSR state; config2 SHALL equal the bit-reversed LFSR state.
REQ-025 config1 and config2 SHALL remain stable from PRECHARGE through SAMPLE of each bit.
REQ-026 DONE SHALL hold resp_valid=1 and keep response stable until resp_ready=1; the FSM SHALL then return to IDLE on the next edge.
REQ-027 start SHALL be ignored in every non-IDLE state, including DONE.
REQ-028 start in the IDLE cycle right after a DONE handshake SHALL be accepted.
REQ-029 resp_ready while resp_valid=0 SHALL have no effect.

Reset
REQ-030 On rst_n=0, the FSM SHALL enter IDLE immediately, including mid-evaluation.
REQ-031 On rst_n=0, busy, resp_valid, puf_a, puf_b, the counters, response, config1 and config2 SHALL all be 0.
REQ-032 An in-flight response SHALL be discarded on reset with no resp_valid pulse; operation SHALL resume on the first edge after rst_n=1.

Configuration
REQ-033 With macro PUF_MAJORITY_VOTE_EN defined, each bit SHALL run PRECHARGE..SAMPLE three times on the same challenge.
REQ-034 Under PUF_MAJORITY_VOTE_EN, the stored bit SHALL be the majority of the three puf_c samples; the LFSR step and counter increment SHALL occur only after the third sample.
REQ-035 Under PUF_MAJORITY_VOTE_EN, per-bit latency SHALL be 3*(2*SETTLE_CYCLES+2) cycles.
REQ-036 Without PUF_MAJORITY_VOTE_EN, there SHALL be a single evaluation per bit and no vote logic.

Structure
REQ-037 Package puf_ctrl_pkg SHALL hold the state enum, the LFSR tap constants, and the 128-bit width constant.
REQ-038 Sub-module puf_lfsr128 SHALL contain the LFSR, with load, step, seed and state ports.

Verification
REQ-039 Stub puf_c=config1[0] at SAMPLE, challenge=128'h1, defaults: resp_valid at cycle 576; response = bit0 of 32 successive LFSR states per the reference model.
REQ-040 challenge=0 SHALL give a response identical to challenge=128'h1.
REQ-041 Hold resp_ready=0 for 50 cycles in DONE: resp_valid stays 1, response is stable, and start pulses are ignored; then resp_ready=1 -> IDLE next cycle.
REQ-042 Assert rst_n=0 at cycle 100 of an evaluation: all outputs are 0 immediately; a new start after release completes normally in 576 cycles.
REQ-043 RESP_BITS=1, SETTLE_CYCLES=1: resp_valid at cycle 4; back-to-back start right after the handshake is accepted.
REQ-044 PUF_MAJORITY_VOTE_EN with stub puf_c pattern 1,0,1 per bit: every stored bit is 1 and resp_valid is at cycle 1728.
